// File: rtl/lsu_pkg.sv
// ============================================================================
// lsu_pkg : shared FSM state encoding and access-size codes for the LSU port.
// Revision: 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// lsu_align : byte-lane mask, store-data replication and load extract/extend.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  mask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    mask_o   = 4'b0000;
    wdata_o  = 32'h0;
    rdata_o  = 32'h0;
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
    case (size_i)
      SZ_BYTE: begin
        mask_o  = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{~uns_i & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        mask_o  = 4'b0011 << addr_lo_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{~uns_i & half_sel[15]}}, half_sel};
      end
      SZ_WORD: begin
        mask_o  = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_port.sv
// ============================================================================
// lsu_port : single-outstanding load/store port between a core and a word RAM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_port
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_unsigned,
  input  logic [31:0]       cpu_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_request,
  output logic              mem_we_re,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  output logic [3:0]        mem_mask,
  input  logic [31:0]       mem_data_out
);

  lsu_state_e        state_q, state_d;
  logic              we_q;
  logic [ADDR_W+1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       wdata_q;
  logic              err_q;

  logic              accept;
  logic              illegal;
  logic [3:0]        lane_mask;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_rdata;

  assign accept  = cpu_valid && (state_q == ST_IDLE);
  assign illegal = (cpu_size == SZ_ILL)
                || ((cpu_size == SZ_HALF) && cpu_addr[0])
                || ((cpu_size == SZ_WORD) && (cpu_addr[1:0] != 2'b00))
                || (cpu_addr[31:ADDR_W+2] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= cpu_we;
        addr_q  <= cpu_addr[ADDR_W+1:0];
        size_q  <= cpu_size;
        uns_q   <= cpu_unsigned;
        wdata_q <= cpu_wdata;
        err_q   <= illegal;
      end
    end
  end

  // Illegal accesses skip ISSUE so the memory never sees them.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cpu_valid) state_d = illegal ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  lsu_align u_align (
    .size_i    (size_q),
    .addr_lo_i (addr_q[1:0]),
    .uns_i     (uns_q),
    .wdata_i   (wdata_q),
    .rdata_i   (mem_data_out),
    .mask_o    (lane_mask),
    .wdata_o   (lane_wdata),
    .rdata_o   (lane_rdata)
  );

  // Memory-side outputs are gated to ISSUE so they read zero at all other times.
  always_comb begin
    cpu_ready   = (state_q == ST_IDLE);
    mem_request = 1'b0;
    mem_we_re   = 1'b0;
    mem_address = '0;
    mem_mask    = 4'b0000;
    mem_data_in = 32'h0;
    rsp_valid   = 1'b0;
    rsp_err     = 1'b0;
    rsp_rdata   = 32'h0;
    if (state_q == ST_ISSUE) begin
      mem_request = 1'b1;
      mem_we_re   = we_q;
      mem_address = addr_q[ADDR_W+1:2];
      mem_mask    = lane_mask;
      mem_data_in = lane_wdata;
    end
    if (state_q == ST_RESP) begin
      rsp_valid = 1'b1;
      rsp_err   = err_q;
      rsp_rdata = (err_q || we_q) ? 32'h0 : lane_rdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_port.sv
// ============================================================================
// tb_lsu_port : directed self-checking bench for lsu_port with a word RAM model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lsu_port;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_valid, cpu_ready, cpu_we, cpu_unsigned;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [1:0]  cpu_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_request, mem_we_re;
  logic [7:0]  mem_address;
  logic [31:0] mem_data_in, mem_data_out;
  logic [3:0]  mem_mask;

  logic [31:0] mem [0:255];
  int          req_cnt = 0;
  int          r0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  lsu_port #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_size(cpu_size), .cpu_unsigned(cpu_unsigned),
    .cpu_wdata(cpu_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_mask(mem_mask), .mem_data_out(mem_data_out)
  );

  // Synchronous RAM: masked writes, read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_request) begin
      req_cnt <= req_cnt + 1;
      if (mem_we_re) begin
        for (int b = 0; b < 4; b++)
          if (mem_mask[b]) mem[mem_address][8*b +: 8] <= mem_data_in[8*b +: 8];
      end else begin
        mem_data_out <= mem[mem_address];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata);
    cpu_valid    = 1'b1;
    cpu_we       = we;
    cpu_addr     = addr;
    cpu_size     = size;
    cpu_unsigned = uns;
    cpu_wdata    = wdata;
    r0           = req_cnt;
    tick();
    cpu_valid = 1'b0;
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_idle_ready"}, {31'b0, cpu_ready}, 32'd1);
    chk({tag, "_idle_rspv"},  {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4]       = 32'h80F0_1234;
    mem_data_out = 32'h0;
    rst_n        = 1'b0;
    cpu_valid    = 1'b0;
    cpu_we       = 1'b0;
    cpu_addr     = 32'h0;
    cpu_size     = SZ_BYTE;
    cpu_unsigned = 1'b0;
    cpu_wdata    = 32'h0;
    rsp_ready    = 1'b0;
    repeat (2) tick();

    chk("rst_memreq", {31'b0, mem_request}, 32'd0);
    chk("rst_rspv",   {31'b0, rsp_valid},   32'd0);
    chk("rst_err",    {31'b0, rsp_err},     32'd0);
    chk("rst_mask",   {28'b0, mem_mask},    32'd0);
    chk("rst_rdata",  rsp_rdata,            32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_ready", {31'b0, cpu_ready}, 32'd1);

    // Load half signed from 0x12: upper half of word 4.
    send(1'b0, 32'h12, SZ_HALF, 1'b0, 32'h0);
    chk("lhs_req",  {31'b0, mem_request}, 32'd1);
    chk("lhs_we",   {31'b0, mem_we_re},   32'd0);
    chk("lhs_addr", {24'b0, mem_address}, 32'h04);
    chk("lhs_mask", {28'b0, mem_mask},    32'hC);
    chk("lhs_rdy",  {31'b0, cpu_ready},   32'd0);
    tick();
    chk("lhs_rspv",  {31'b0, rsp_valid},   32'd1);
    chk("lhs_data",  rsp_rdata,            32'hFFFF_80F0);
    chk("lhs_err",   {31'b0, rsp_err},     32'd0);
    chk("lhs_req0",  {31'b0, mem_request}, 32'd0);
    finish_rsp("lhs");

    send(1'b0, 32'h12, SZ_HALF, 1'b1, 32'h0);
    tick();
    chk("lhu_data", rsp_rdata, 32'h0000_80F0);
    finish_rsp("lhu");

    // Store byte 0xA5 at 0x13: lane 3 of word 4.
    send(1'b1, 32'h13, SZ_BYTE, 1'b0, 32'h1234_56A5);
    chk("sb_req",  {31'b0, mem_request}, 32'd1);
    chk("sb_we",   {31'b0, mem_we_re},   32'd1);
    chk("sb_addr", {24'b0, mem_address}, 32'h04);
    chk("sb_mask", {28'b0, mem_mask},    32'h8);
    chk("sb_data", mem_data_in,          32'hA5A5_A5A5);
    chk("sb_rspv0", {31'b0, rsp_valid},  32'd0);
    tick();
    chk("sb_rspv",  {31'b0, rsp_valid}, 32'd1);
    chk("sb_err",   {31'b0, rsp_err},   32'd0);
    chk("sb_rdata", rsp_rdata,          32'd0);
    chk("sb_cnt",   req_cnt - r0,       32'd1);
    finish_rsp("sb");

    send(1'b0, 32'h13, SZ_BYTE, 1'b1, 32'h0);
    tick();
    chk("lbu_data", rsp_rdata, 32'h0000_00A5);
    finish_rsp("lbu");
    send(1'b0, 32'h13, SZ_BYTE, 1'b0, 32'h0);
    tick();
    chk("lb_data", rsp_rdata, 32'hFFFF_FFA5);
    finish_rsp("lb");
    send(1'b0, 32'h10, SZ_WORD, 1'b0, 32'h0);
    tick();
    chk("lw_data", rsp_rdata, 32'hA5F0_1234);
    finish_rsp("lw");

    // Store half 0xBEEF at 0x22 (upper half of word 8).
    send(1'b1, 32'h22, SZ_HALF, 1'b0, 32'hFFFF_BEEF);
    chk("sh_mask", {28'b0, mem_mask}, 32'hC);
    chk("sh_data", mem_data_in,       32'hBEEF_BEEF);
    chk("sh_addr", {24'b0, mem_address}, 32'h08);
    tick();
    finish_rsp("sh");

    // Stalled load word from 0x20 with inputs wiggling underneath.
    send(1'b0, 32'h20, SZ_WORD, 1'b0, 32'h0);
    cpu_valid = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 32'h44;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_rspv",  {31'b0, rsp_valid}, 32'd1);
      chk("stall_data",  rsp_rdata,          32'hBEEF_0000);
      chk("stall_ready", {31'b0, cpu_ready}, 32'd0);
      cpu_addr  = 32'h100 + 32'(i * 4);
      cpu_size  = 2'(i);
      tick();
    end
    cpu_valid = 1'b0;
    chk("stall_end", rsp_rdata, 32'hBEEF_0000);
    finish_rsp("stall");
    chk("stall_cnt", req_cnt - r0, 32'd1);

    // Misaligned word load: error response after one cycle, no memory access.
    send(1'b0, 32'h6, SZ_WORD, 1'b0, 32'h0);
    chk("mis_rspv",  {31'b0, rsp_valid},   32'd1);
    chk("mis_err",   {31'b0, rsp_err},     32'd1);
    chk("mis_rdata", rsp_rdata,            32'd0);
    chk("mis_req",   {31'b0, mem_request}, 32'd0);
    finish_rsp("mis");
    chk("mis_cnt", req_cnt - r0, 32'd0);

    send(1'b0, 32'h400, SZ_BYTE, 1'b0, 32'h0);
    chk("oor_err", {31'b0, rsp_err},     32'd1);
    chk("oor_req", {31'b0, mem_request}, 32'd0);
    finish_rsp("oor");
    chk("oor_cnt", req_cnt - r0, 32'd0);

    send(1'b0, 32'h0, SZ_ILL, 1'b0, 32'h0);
    chk("ill_err", {31'b0, rsp_err},     32'd1);
    chk("ill_req", {31'b0, mem_request}, 32'd0);
    finish_rsp("ill");
    chk("ill_cnt", req_cnt - r0, 32'd0);

    // Reset asserted while in ISSUE.
    send(1'b1, 32'h10, SZ_WORD, 1'b0, 32'hDEAD_BEEF);
    chk("rio_req_pre", {31'b0, mem_request}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rio_req",  {31'b0, mem_request}, 32'd0);
    chk("rio_mask", {28'b0, mem_mask},    32'd0);
    chk("rio_addr", {24'b0, mem_address}, 32'd0);
    chk("rio_data", mem_data_in,          32'd0);
    chk("rio_we",   {31'b0, mem_we_re},   32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rio_rspv",  {31'b0, rsp_valid}, 32'd0);
      chk("rio_ready", {31'b0, cpu_ready}, 32'd1);
      tick();
    end
    chk("rio_cnt", req_cnt - r0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu_port.md
LSU_PORT -- requirements
Module: lsu_port

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the word-address width of the attached data memory (256 words).
REQ-002 SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have the port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have the port cpu_valid, input, 1 bit: core presents a load/store request.
REQ-005 SHALL have the port cpu_ready, output, 1 bit: the request is accepted when cpu_valid && cpu_ready.
REQ-006 SHALL have the port cpu_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have the port cpu_addr, input, 32 bits: byte address.
REQ-008 SHALL have the port cpu_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have the port cpu_unsigned, input, 1 bit: 1 = zero-extend loads, 0 = sign-extend.
REQ-010 SHALL have the port cpu_wdata, input, 32 bits: store data, right-aligned.
REQ-011 SHALL have the port rsp_valid, output, 1 bit: a response is present.
REQ-012 SHALL have the port rsp_ready, input, 1 bit: the core consumes the response.
REQ-013 SHALL have the port rsp_rdata, output, 32 bits: extended load data; 0 for stores and errors.
REQ-014 SHALL have the port rsp_err, output, 1 bit: misaligned, illegal-size or out-of-range access.
REQ-015 SHALL have the port mem_request, output, 1 bit: memory access strobe.
REQ-016 SHALL have the port mem_we_re, output, 1 bit: 1 = write, 0 = read.
REQ-017 SHALL have the port mem_address, output, ADDR_W bits: word address, cpu_addr[ADDR_W+1:2].
REQ-018 SHALL have the port mem_data_in, output, 32 bits: lane-replicated store data.
REQ-019 SHALL have the port mem_mask, output, 4 bits: byte-lane enables.
REQ-020 SHALL have the port mem_data_out, input, 32 bits: read word, valid from the cycle after a read strobe and held until the next read.

Function
REQ-021 SHALL implement the FSM states IDLE, ISSUE and RESP, with cpu_ready = (state == IDLE).
REQ-022 SHALL, on acceptance in IDLE, register we, addr, size, unsigned and wdata.
REQ-023 SHALL, on acceptance in IDLE, go to ISSUE when the access is legal, or to RESP with the error flag set when it is not.
REQ-024 SHALL treat an access as illegal when any of these holds: size 11; half with addr[0] = 1; word with addr[1:0] != 0; addr[31:ADDR_W+2] != 0.
REQ-025 SHALL, in ISSUE, assert mem_request for exactly one cycle with registered address, mask and data, then go to RESP.
REQ-026 SHALL, in RESP, assert rsp_valid and hold all rsp_* outputs stable until rsp_ready.
REQ-027 SHALL return to IDLE on the RESP cycle in which rsp_ready = 1; the next request is accepted in the following cycle.
REQ-028 SHALL keep rsp_valid low outside RESP and mem_request low outside ISSUE.
REQ-029 SHALL drive mem_mask as follows: byte = 4'b0001 << addr[1:0]; half = 4'b0011 << addr[1:0]; word = 4'b1111.
REQ-030 SHALL drive mem_data_in as follows: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
REQ-031 SHALL, for loads in RESP, take the byte or half selected by addr[1:0] from mem_data_out and extend it to 32 bits per cpu_unsigned.
REQ-032 SHALL have legal-access latency from acceptance to rsp_valid of exactly 2 cycles, and error latency of 1 cycle.
REQ-033 SHALL never assert mem_request for an error access.
REQ-034 SHALL ignore cpu_valid and input changes while in ISSUE or RESP.

Reset
REQ-035 SHALL, while rst_n = 0, immediately force state IDLE and drive mem_request, rsp_valid, rsp_err = 0, and rsp_rdata, mem_mask, mem_data_in, mem_address, mem_we_re = 0.
REQ-036 SHALL abandon any in-flight transaction on reset assertion mid-operation and issue no response for it after release.
REQ-037 SHALL have cpu_ready = 1 in the first cycle after reset release.

Structure
REQ-038 SHALL place the FSM state encoding and the cpu_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) in a shared package, lsu_pkg.
REQ-039 SHALL implement lane logic (mask, store replication, load extract/extend) in one combinational sub-module, lsu_align.

Verification
REQ-040 SHALL cover: store byte 0xA5 at addr 0x0000_0013 -> mem_request 1 cycle, mem_address 0x04, mem_mask 1000, mem_data_in 0xA5A5A5A5, rsp_valid 2 cycles after accept, rsp_err 0.
REQ-041 SHALL cover: with memory word 0x80F0_1234 at index 4, load half signed at addr 0x12 -> rsp_rdata 0xFFFF80F0; unsigned -> 0x000080F0.
REQ-042 SHALL cover: load word at addr 0x0000_0006 -> rsp_err 1, rsp_rdata 0, rsp_valid 1 cycle after accept, no mem_request.
REQ-043 SHALL cover: address 0x0000_0400, and size 11 -> rsp_err 1, no mem_request.
REQ-044 SHALL cover: rsp_ready held low 5 cycles -> rsp_valid/rsp_rdata stable, cpu_ready 0, single mem_request only.
REQ-045 SHALL cover: rst_n asserted during ISSUE -> outputs zero immediately, no rsp_valid after release, cpu_ready 1.
